md5_core_stream: RTL and testbench

MD5_CORE_STREAM -- requirements
Module: md5_core_stream

---
 rtl/md5_core_stream_if.sv | 14 +
 rtl/md5_core_stream.sv | 117 +++++++++++
 tb/tb_md5_core_stream.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/md5_core_stream_if.sv
// md5_core_stream_if: block-in / digest-out handshake bundle for the MD5 core
interface md5_core_stream_if;
   logic         blk_valid;
   logic         blk_ready;
   logic         blk_first;
   logic [511:0] blk_data;
   logic         dig_valid;
   logic         dig_ready;
   logic [127:0] digest;
   modport master (output blk_valid, blk_first, blk_data, dig_ready,
                   input  blk_ready, dig_valid, digest);
   modport slave  (input  blk_valid, blk_first, blk_data, dig_ready,
                   output blk_ready, dig_valid, digest);
endinterface

// File: rtl/md5_core_stream.sv
// md5_core_stream: streaming MD5 compression core, UNROLL steps per clock, one digest per block
module md5_core_stream #(
   parameter int UNROLL = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   md5_core_stream_if.slave bus,
   output logic             busy
);
   localparam logic [127:0] IV = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};
   localparam logic [5:0] LAST = 6'(64 - UNROLL);
   localparam logic [31:0] K [64] = '{
      32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
      32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
      32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
      32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
      32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
      32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
      32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
      32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391};
   localparam logic [4:0] SH [16] = '{5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9, 5'd14, 5'd20,
                                      5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21};

   if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
      $error("md5_core_stream: UNROLL must be 1, 2 or 4");
   end

   typedef enum logic [1:0] {IDLE, ROUND, SUM, DONE} state_t;
   state_t       state, state_nx;
   logic         accept;
   logic [511:0] blk;
   logic [5:0]   cnt, idx;
   logic [31:0]  a, b, c, d, ha, hb, hc, hd;
   logic [31:0]  na, nb, nc, nd, tmp;

   function automatic logic [31:0] bswap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
      logic [63:0] y;
      y = {x, x} << s;
      return y[63:32];
   endfunction

   function automatic logic [31:0] word(input logic [511:0] m, input logic [3:0] j);
      return bswap(m[32 * (15 - int'(j)) +: 32]);
   endfunction

   function automatic logic [3:0] msg_idx(input logic [5:0] i);
      return i[5:4] == 2'd0 ? i[3:0] :
             i[5:4] == 2'd1 ? 4'(5 * i + 1) :
             i[5:4] == 2'd2 ? 4'(3 * i + 5) : 4'(7 * i);
   endfunction

   function automatic logic [31:0] fun(input logic [1:0] r, input logic [31:0] x, y, z);
      return r == 2'd0 ? (x & y) | (~x & z) :
             r == 2'd1 ? (x & z) | (y & ~z) :
             r == 2'd2 ? x ^ y ^ z : y ^ (x | ~z);
   endfunction

   // UNROLL chained MD5 steps starting at step cnt
   always_comb begin
      na = a;
      nb = b;
      nc = c;
      nd = d;
      idx = cnt;
      tmp = '0;
      for (int k = 0; k < UNROLL; k++) begin
         idx = cnt + 6'(k);
         tmp = na + fun(idx[5:4], nb, nc, nd) + K[idx] + word(blk, msg_idx(idx));
         na = nd;
         nd = nc;
         nc = nb;
         nb = nb + rotl(tmp, SH[{idx[5:4], idx[1:0]}]);
      end
   end

   // state register, reset aborts any block in flight
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;

   // next-state: DONE can hand straight over to ROUND when a block arrives with the handshake
   always_comb
      state_nx = state == IDLE  ? (accept ? ROUND : IDLE) :
                 state == ROUND ? (cnt == LAST ? SUM : ROUND) :
                 state == SUM   ? DONE :
                 accept ? ROUND : bus.dig_ready ? IDLE : DONE;

   // handshake outputs and byte-ordered digest
   always_comb begin
      bus.blk_ready = state == IDLE || (state == DONE && bus.dig_ready);
      bus.dig_valid = state == DONE;
      busy = state != IDLE;
      accept = bus.blk_valid && bus.blk_ready;
      bus.digest = {bswap(ha), bswap(hb), bswap(hc), bswap(hd)};
   end

   // chain registers: IV on reset or first block, feed-forward add in SUM
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {ha, hb, hc, hd} <= IV;
      else if (accept && bus.blk_first) {ha, hb, hc, hd} <= IV;
      else if (state == SUM) {ha, hb, hc, hd} <= {ha + a, hb + b, hc + c, hd + d};

   // working registers, step counter and latched block
   always_ff @(posedge clk)
      if (accept) begin
         blk <= bus.blk_data;
         cnt <= '0;
         {a, b, c, d} <= bus.blk_first ? IV : {ha, hb, hc, hd};
      end else if (state == ROUND) begin
         {a, b, c, d} <= {na, nb, nc, nd};
         cnt <= cnt + 6'(UNROLL);
      end
endmodule

// File: tb/tb_md5_core_stream.sv
// tb_md5_core_stream: directed + random checks of three md5_core_stream instances (UNROLL 1, 2, 4)
module tb_md5_core_stream;
   localparam logic [127:0] IV = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};
   localparam int RS [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

   logic         clk = 0, rst_n = 1;
   logic         blk_valid [3], blk_first [3], dig_ready [3];
   logic         blk_ready [3], dig_valid [3], busy [3];
   logic [511:0] blk_data [3];
   logic [127:0] digest [3], got [3], mh [3], exp_h [3];
   logic [31:0]  tk [64];
   int           errors = 0, checks = 0;

   always #5 clk = ~clk;

   for (genvar j = 0; j < 3; j++) begin : g_dut
      md5_core_stream_if bus ();
      assign bus.blk_valid = blk_valid[j];
      assign bus.blk_first = blk_first[j];
      assign bus.blk_data = blk_data[j];
      assign bus.dig_ready = dig_ready[j];
      assign blk_ready[j] = bus.blk_ready;
      assign dig_valid[j] = bus.dig_valid;
      assign digest[j] = bus.digest;
      md5_core_stream #(.UNROLL(1 << j)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy[j]));
   end

   function automatic logic [31:0] bs(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   function automatic logic [127:0] to_dig(input logic [127:0] h);
      return {bs(h[127:96]), bs(h[95:64]), bs(h[63:32]), bs(h[31:0])};
   endfunction

   function automatic logic [127:0] md5_ref(input logic [127:0] h, input logic [511:0] blk);
      logic [31:0] m [16];
      logic [31:0] a, b, c, d, f, t;
      int g, s;
      for (int j = 0; j < 16; j++)
         for (int q = 0; q < 4; q++)
            m[j][8 * q +: 8] = blk[511 - 8 * (4 * j + q) -: 8];
      {a, b, c, d} = h;
      for (int i = 0; i < 64; i++) begin
         case (i / 16)
            0: begin f = (b & c) | (~b & d); g = i; end
            1: begin f = (b & d) | (c & ~d); g = (5 * i + 1) % 16; end
            2: begin f = b ^ c ^ d; g = (3 * i + 5) % 16; end
            default: begin f = c ^ (b | ~d); g = (7 * i) % 16; end
         endcase
         t = a + f + tk[i] + m[g];
         s = RS[4 * (i / 16) + i % 4];
         t = (t << s) | (t >> (32 - s));
         {a, b, c, d} = {d, b + t, b, c};
      end
      return {h[127:96] + a, h[95:64] + b, h[63:32] + c, h[31:0] + d};
   endfunction

   function automatic logic [511:0] rnd512();
      logic [511:0] r;
      for (int k = 0; k < 16; k++) r[32 * k +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [511:0] rfc_blk(input bit second);
      logic [511:0] r = '0;
      for (int n = 0; n < (second ? 16 : 64); n++)
         r[511 - 8 * n -: 8] = 8'(48 + ((n + (second ? 64 : 0)) % 10 + 1) % 10);
      if (second) begin
         r[383 -: 8] = 8'h80;
         r[63:56] = 8'h80;
         r[55:48] = 8'h02;
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic accept(input int u, input logic [511:0] data, input logic first);
      int n = 0;
      blk_data[u] = data;
      blk_first[u] = first;
      blk_valid[u] = 1;
      while (!blk_ready[u] && n < 200) begin
         tick();
         n++;
      end
      chk($sformatf("accept_ready_u%0d", u), 128'(blk_ready[u]), 128'(1));
      tick();
      blk_valid[u] = 0;
      blk_data[u] = rnd512();
      if (first) mh[u] = IV;
      exp_h[u] = md5_ref(mh[u], data);
      mh[u] = exp_h[u];
   endtask

   task automatic wait_dig(input int u, input bit noise);
      int n = 0;
      while (!dig_valid[u] && n < 200) begin
         chk($sformatf("ready_low_busy_u%0d", u), 128'({blk_ready[u], busy[u]}), 128'(2'b01));
         if (noise) begin
            blk_valid[u] = 1'($urandom);
            blk_data[u] = rnd512();
         end
         tick();
         n++;
      end
      blk_valid[u] = 0;
      chk($sformatf("latency_u%0d", u), 128'(n), 128'(64 / (1 << u) + 1));
      chk($sformatf("digest_u%0d", u), digest[u], to_dig(exp_h[u]));
      got[u] = digest[u];
   endtask

   task automatic take(input int u, input int hold);
      for (int i = 0; i < hold; i++) begin
         chk($sformatf("hold_digest_u%0d", u), digest[u], got[u]);
         chk($sformatf("hold_ctl_u%0d", u), 128'({dig_valid[u], blk_ready[u], busy[u]}), 128'(3'b101));
         tick();
      end
      dig_ready[u] = 1;
      #1;
      chk($sformatf("done_ready_u%0d", u), 128'(blk_ready[u]), 128'(1));
      tick();
      dig_ready[u] = 0;
      chk($sformatf("idle_after_u%0d", u), 128'({dig_valid[u], busy[u], blk_ready[u]}), 128'(3'b001));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [511:0] abc, empty, b1, b2;
      int seen;
      real x;
      for (int i = 0; i < 64; i++) begin
         x = $sin(real'(i + 1));
         tk[i] = 32'(longint'($floor((x < 0.0 ? -x : x) * 4294967296.0)));
      end
      abc = {32'h61626380, 416'h0, 8'h18, 56'h0};
      empty = {8'h80, 504'h0};
      b1 = rfc_blk(0);
      b2 = rfc_blk(1);
      for (int u = 0; u < 3; u++) begin
         blk_valid[u] = 0;
         blk_first[u] = 0;
         dig_ready[u] = 0;
         blk_data[u] = '0;
         mh[u] = IV;
      end
      #1 rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      for (int u = 0; u < 3; u++)
         chk($sformatf("reset_u%0d", u), 128'({busy[u], dig_valid[u]}), 128'(0));
      rst_n = 1;
      #1;
      for (int u = 0; u < 3; u++)
         chk($sformatf("reset_ready_u%0d", u), 128'(blk_ready[u]), 128'(1));
      tick();

      dig_ready[0] = 1;
      accept(0, abc, 1);
      wait_dig(0, 0);
      chk("abc_const", got[0], 128'h900150983cd24fb0d6963f7d28e17f72);
      take(0, 0);

      accept(2, empty, 1);
      wait_dig(2, 1);
      chk("empty_const", got[2], 128'hd41d8cd98f00b204e9800998ecf8427e);
      take(2, 0);

      for (int u = 0; u < 3; u++) begin
         accept(u, b1, 1);
         wait_dig(u, 1);
         blk_data[u] = b2;
         blk_first[u] = 0;
         blk_valid[u] = 1;
         #1;
         chk($sformatf("done_ready_held_u%0d", u), 128'(blk_ready[u]), 128'(0));
         dig_ready[u] = 1;
         #1;
         chk($sformatf("done_ready_rel_u%0d", u), 128'(blk_ready[u]), 128'(1));
         accept(u, b2, 0);
         dig_ready[u] = 0;
         chk($sformatf("overlap_consumed_u%0d", u), 128'({dig_valid[u], busy[u]}), 128'(2'b01));
         wait_dig(u, 1);
         chk($sformatf("rfc80_const_u%0d", u), got[u], 128'h57edf4a22be3c955ac49da2e2107b67a);
         take(u, 0);
      end

      accept(0, rnd512(), 1);
      wait_dig(0, 1);
      take(0, 20);

      accept(0, abc, 1);
      repeat (30) tick();
      rst_n = 0;
      #1;
      chk("mid_reset", 128'({busy[0], dig_valid[0], blk_ready[0]}), 128'(3'b001));
      rst_n = 1;
      for (int u = 0; u < 3; u++) mh[u] = IV;
      seen = 0;
      repeat (80) begin
         tick();
         seen = seen | int'(dig_valid[0]);
      end
      chk("aborted_no_digest", 128'(seen), 128'(0));
      accept(0, abc, 0);
      wait_dig(0, 1);
      chk("abc_after_reset", got[0], 128'h900150983cd24fb0d6963f7d28e17f72);
      take(0, 2);

      for (int it = 0; it < 12; it++) begin
         int u;
         u = $urandom_range(0, 2);
         accept(u, rnd512(), 1'($urandom_range(0, 3) == 0));
         wait_dig(u, 1);
         take(u, $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
